// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon sequence player and its lamp decoder.
package simon_pkg;

   localparam int DEF_NUM_LEDS = 4;
   localparam int DEF_MAX_LEN  = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_LOAD,
      S_ON,
      S_OFF,
      S_DONE
   } player_state_t;

   typedef logic [$clog2(DEF_NUM_LEDS)-1:0] led_idx_t;

   // Base time divided by 2^sp, clamped to at least one clock.
   function automatic int unsigned scaled_time(input int unsigned base, input logic [1:0] sp);
      int unsigned t;
      t = base >> sp;
      return (t == 0) ? 1 : t;
   endfunction

endpackage

// File: rtl/led_onehot_decoder.sv
// Combinational lamp index to zero-extended one-hot drive; zero output and bad=1 for indices >= NUM_LEDS.
module led_onehot_decoder #(
   parameter int NUM_LEDS = 4,
   parameter int OUT_W    = 10,
   parameter int IDX_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic [IDX_W-1:0] idx,
   output logic [OUT_W-1:0] onehot,
   output logic             bad
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         onehot[i] = (idx == IDX_W'(i));
      end
      bad = (32'(idx) >= NUM_LEDS);
   end

endmodule

// File: rtl/sequence_player.sv
// Plays len+1 stored lamp indices with on/off timing scaled by 2^speed; one item takes 2+on_t+off_t clocks.
// Registered outputs only; abort returns to IDLE on the next edge and start is ignored while busy.
module sequence_player
   import simon_pkg::*;
#(
   parameter int          NUM_LEDS = DEF_NUM_LEDS,
   parameter int          OUT_W    = 10,
   parameter int          MAX_LEN  = DEF_MAX_LEN,
   parameter int unsigned ON_CYC   = 25_000_000,
   parameter int unsigned OFF_CYC  = 25_000_000,
   parameter int          IDX_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
   parameter int          AW       = $clog2(MAX_LEN)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [AW-1:0]    len,
   input  logic [1:0]       speed,
   input  logic             abort,
   output logic [AW-1:0]    mem_addr,
   input  logic [IDX_W-1:0] mem_data,
   output logic [OUT_W-1:0] led_out,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int unsigned MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
   localparam int          TW      = $clog2(MAX_CYC + 1);

   player_state_t    state;
   logic [TW-1:0]    timer;
   logic [AW-1:0]    len_q;
   logic [1:0]       speed_q;
   logic [TW-1:0]    on_load;
   logic [TW-1:0]    off_load;
   logic [OUT_W-1:0] dec_onehot;
   logic             dec_bad;

   assign on_load  = TW'(scaled_time(ON_CYC, speed_q) - 1);
   assign off_load = TW'(scaled_time(OFF_CYC, speed_q) - 1);

   // Decoded straight from the memory output so the lamp lights on the edge leaving LOAD.
   led_onehot_decoder #(
      .NUM_LEDS (NUM_LEDS),
      .OUT_W    (OUT_W),
      .IDX_W    (IDX_W)
   ) u_dec (
      .idx    (mem_data),
      .onehot (dec_onehot),
      .bad    (dec_bad)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         timer    <= '0;
         len_q    <= '0;
         speed_q  <= '0;
         mem_addr <= '0;
         led_out  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else if (abort && state != S_IDLE) begin
         state   <= S_IDLE;
         led_out <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && !abort) begin
                  len_q    <= len;
                  speed_q  <= speed;
                  err      <= 1'b0;
                  mem_addr <= '0;
                  busy     <= 1'b1;
                  state    <= S_ADDR;
               end
            end
            S_ADDR: state <= S_LOAD;
            S_LOAD: begin
               led_out <= dec_onehot;
               if (dec_bad) err <= 1'b1;
               timer   <= on_load;
               state   <= S_ON;
            end
            S_ON: begin
               if (timer == '0) begin
                  led_out <= '0;
                  timer   <= off_load;
                  state   <= S_OFF;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            S_OFF: begin
               if (timer == '0) begin
                  if (mem_addr == len_q) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     mem_addr <= mem_addr + 1'b1;
                     state    <= S_ADDR;
                  end
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
